// File: rtl/screen_pkg.sv
// Shared definitions for the screen painters: pattern modes, the byte
// constants that build them, and the writer FSM state encoding.
package screen_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR   = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_BORDER  = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] BYTE_ZERO  = 8'h00;
  localparam logic [7:0] BYTE_FULL  = 8'hFF;
  localparam logic [7:0] EDGE_LEFT  = 8'h01;  // LSB is the leftmost pixel
  localparam logic [7:0] EDGE_RIGHT = 8'h80;
  localparam logic [7:0] CHK_EVEN   = 8'hAA;
  localparam logic [7:0] CHK_ODD    = 8'h55;

endpackage

// File: rtl/screen_pattern_writer_if.sv
// Control-side request/status signals and the screen RAM write port of
// the pattern writer, bundled so the painter and its users share one
// definition.
//
// Handshake: start is a request that is accepted only when the writer is
// idle (state IDLE); requests seen while busy or during the done cycle
// are dropped, not queued. mode and fill_byte are captured on the
// accepting edge only. abort cancels a running frame on the next edge.
// wr_en is a one-cycle write strobe with no back-pressure: every cycle
// with wr_en=1 is exactly one RAM write of wr_data to wr_addr. done is a
// single-cycle pulse following the last write of a completed frame.
interface screen_pattern_writer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  import screen_pkg::*;

  logic              start;
  logic [1:0]        mode;
  logic [7:0]        fill_byte;
  logic              abort;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  state_t            state;  // live FSM state for checkers and debug

  modport master (
    output start, mode, fill_byte, abort,
    input  busy, done, wr_en, wr_addr, wr_data, state
  );

  modport slave (
    input  start, mode, fill_byte, abort,
    output busy, done, wr_en, wr_addr, wr_data, state
  );

endinterface

// File: rtl/screen_pattern_gen.sv
// Combinational pattern source: given the mode and the position flags of
// the byte being written, returns the screen byte. Kept free of counters
// so other painters can reuse it.
module screen_pattern_gen
  import screen_pkg::*;
(
  input  mode_t      mode,
  input  logic [7:0] fill_byte,
  input  logic       row_odd,
  input  logic       first_row,
  input  logic       last_row,
  input  logic       first_col,
  input  logic       last_col,
  output logic [7:0] pattern
);

  // Select the byte for the current position from the latched mode.
  always_comb begin
    pattern = BYTE_ZERO;
    case (mode)
      MODE_CLEAR:   pattern = BYTE_ZERO;
      MODE_FILL:    pattern = fill_byte;
      MODE_BORDER: begin
        if (first_row || last_row) begin
          pattern = BYTE_FULL;
        end else begin
          // A one-byte-wide screen has both edges in the same byte.
          pattern = (first_col ? EDGE_LEFT : BYTE_ZERO) |
                    (last_col  ? EDGE_RIGHT : BYTE_ZERO);
        end
      end
      MODE_CHECKER: pattern = row_odd ? CHK_ODD : CHK_EVEN;
      default:      pattern = BYTE_ZERO;
    endcase
  end

endmodule

// File: rtl/screen_pattern_writer.sv
// Writes one full frame of a selectable pattern into the byte-wide screen
// RAM, one byte per clock, in address order. Row/column counters, a
// running row base address (no multiplier), the FSM and all output
// registers live here; the byte itself comes from screen_pattern_gen.
module screen_pattern_writer
  import screen_pkg::*;
#(
  parameter int COLS_BYTES = 16,
  parameter int ROWS       = 128,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  screen_pattern_writer_if.slave bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS_BYTES > 1) ? $clog2(COLS_BYTES) : 1;
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS_BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(COLS_BYTES);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;  // row_q * COLS_BYTES, kept incrementally
  mode_t             mode_q, mode_d;
  logic [7:0]        fill_q, fill_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              first_row, last_row, first_col, last_col;
  logic [7:0]        pattern;

  assign first_row = (row_q == '0);
  assign last_row  = (row_q == ROW_LAST);
  assign first_col = (col_q == '0);
  assign last_col  = (col_q == COL_LAST);

  screen_pattern_gen u_gen (
    .mode      (mode_q),
    .fill_byte (fill_q),
    .row_odd   (row_q[0]),
    .first_row (first_row),
    .last_row  (last_row),
    .first_col (first_col),
    .last_col  (last_col),
    .pattern   (pattern)
  );

  // Next state, counter advance and next output values; the strobes
  // default low and address/data hold unless a write is issued.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    base_d  = base_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        // start wins over abort here; abort only matters while running.
        if (bus.start) begin
          state_d = ST_RUN;
          mode_d  = mode_t'(bus.mode);
          fill_d  = bus.fill_byte;
          row_d   = '0;
          col_d   = '0;
          base_d  = '0;
        end
      end

      ST_RUN: begin
        if (bus.abort) begin
          // Cancel without writing this cycle and without a done pulse.
          state_d = ST_IDLE;
        end else begin
          busy_d  = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = base_q + ADDR_W'(col_q);
          data_d  = DATA_W'(pattern);
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = ST_DONE;
            end else begin
              row_d  = row_q + ROW_W'(1);
              base_d = base_q + BASE_STEP;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
      mode_q  <= MODE_CLEAR;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_screen_pattern_writer.sv
// Bench for screen_pattern_writer: a 16x128 instance and a 1x4 corner
// instance. Starting a frame pushes the whole expected frame (address,
// byte), the first-write cycle and the done cycle into queues; a monitor
// running just after each rising edge pops and compares.
module tb_screen_pattern_writer;
  import screen_pkg::*;

  localparam int C0 = 16;
  localparam int R0 = 128;
  localparam int A0 = 11;
  localparam int N0 = C0 * R0;
  localparam int C1 = 1;
  localparam int R1 = 4;
  localparam int A1 = 2;
  localparam int N1 = C1 * R1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  screen_pattern_writer_if #(.ADDR_W(A0), .DATA_W(8)) bus0 ();
  screen_pattern_writer_if #(.ADDR_W(A1), .DATA_W(8)) bus1 ();

  screen_pattern_writer #(.COLS_BYTES(C0), .ROWS(R0), .ADDR_W(A0), .DATA_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  screen_pattern_writer #(.COLS_BYTES(C1), .ROWS(R1), .ADDR_W(A1), .DATA_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [A0+7:0] exp0_q[$];
  int            first0_q[$];
  int            done0_q[$];
  int            wr_cnt0 = 0;
  logic          prev_en0 = 1'b0;
  logic [A0-1:0] last_addr0 = '0;
  logic [7:0]    last_data0 = '0;
  logic [A0+7:0] e0;

  logic [A1+7:0] exp1_q[$];
  int            done1_q[$];
  int            wr_cnt1 = 0;
  logic [A1-1:0] last_addr1 = '0;
  logic [7:0]    last_data1 = '0;
  logic [A1+7:0] e1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexp(string name, logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got event %0h, want none (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_byte(int mode, logic [7:0] fill, int row, int col,
                                          int rows, int cols);
    logic [7:0] b;
    case (mode)
      0: b = 8'h00;
      1: b = fill;
      2: begin
        if (row == 0 || row == rows - 1) b = 8'hFF;
        else begin
          b = 8'h00;
          if (col == 0) b = b | 8'h01;
          if (col == cols - 1) b = b | 8'h80;
        end
      end
      default: b = (row % 2 == 0) ? 8'hAA : 8'h55;
    endcase
    return b;
  endfunction

  task automatic push_frame0(int mode, logic [7:0] fill, int start_cyc);
    for (int r = 0; r < R0; r++)
      for (int c = 0; c < C0; c++)
        exp0_q.push_back({A0'((r * C0 + c) % (1 << A0)), ref_byte(mode, fill, r, c, R0, C0)});
    first0_q.push_back(start_cyc + 1);
    done0_q.push_back(start_cyc + N0 + 1);
  endtask

  task automatic push_frame1(int mode, logic [7:0] fill, int start_cyc);
    for (int r = 0; r < R1; r++)
      for (int c = 0; c < C1; c++)
        exp1_q.push_back({A1'((r * C1 + c) % (1 << A1)), ref_byte(mode, fill, r, c, R1, C1)});
    done1_q.push_back(start_cyc + N1 + 1);
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      prev_en0 = 1'b0;
    end else begin
      if (bus0.wr_en) begin
        if (!prev_en0) begin
          if (first0_q.size() == 0) fail_unexp("first0_unexpected", 32'(bus0.wr_addr));
          else chk("first0_cycle", cyc, first0_q.pop_front());
        end
        if (exp0_q.size() == 0) begin
          fail_unexp("wr0_unexpected", {bus0.wr_addr, bus0.wr_data});
        end else begin
          e0 = exp0_q.pop_front();
          chk("wr0_addr", 32'(bus0.wr_addr), 32'(e0[A0+7:8]));
          chk("wr0_data", 32'(bus0.wr_data), 32'(e0[7:0]));
          last_addr0 = e0[A0+7:8];
          last_data0 = e0[7:0];
        end
        wr_cnt0++;
      end else begin
        chk("hold0_addr", 32'(bus0.wr_addr), 32'(last_addr0));
        chk("hold0_data", 32'(bus0.wr_data), 32'(last_data0));
      end
      if (bus0.done) begin
        if (done0_q.size() == 0) fail_unexp("done0_unexpected", cyc);
        else chk("done0_cycle", cyc, done0_q.pop_front());
      end
      prev_en0 = bus0.wr_en;

      if (bus1.wr_en) begin
        if (exp1_q.size() == 0) begin
          fail_unexp("wr1_unexpected", {bus1.wr_addr, bus1.wr_data});
        end else begin
          e1 = exp1_q.pop_front();
          chk("wr1_addr", 32'(bus1.wr_addr), 32'(e1[A1+7:8]));
          chk("wr1_data", 32'(bus1.wr_data), 32'(e1[7:0]));
          last_addr1 = e1[A1+7:8];
          last_data1 = e1[7:0];
        end
        wr_cnt1++;
      end else begin
        chk("hold1_addr", 32'(bus1.wr_addr), 32'(last_addr1));
        chk("hold1_data", 32'(bus1.wr_data), 32'(last_data1));
      end
      if (bus1.done) begin
        if (done1_q.size() == 0) fail_unexp("done1_unexpected", cyc);
        else chk("done1_cycle", cyc, done1_q.pop_front());
      end
    end
  end

  // ---------------- drivers: large instance ----------------
  task automatic wait_wr0(int target, int budget);
    int n = 0;
    while (wr_cnt0 < target && n < budget) begin
      @(negedge clk);
      n++;
      bus0.mode      = 2'($urandom);
      bus0.fill_byte = 8'($urandom);
    end
    if (wr_cnt0 < target) fail_unexp("wait_wr0_timeout", wr_cnt0);
  endtask

  task automatic start0(int mode, logic [7:0] fill, bit with_abort);
    @(negedge clk);
    bus0.start     = 1'b1;
    bus0.mode      = 2'(mode);
    bus0.fill_byte = fill;
    bus0.abort     = with_abort;
    push_frame0(mode, fill, cyc + 1);
    @(negedge clk);
    bus0.start     = 1'b0;
    bus0.abort     = 1'b0;
    bus0.mode      = 2'($urandom);
    bus0.fill_byte = 8'($urandom);
  endtask

  task automatic run_frame0(int mode, logic [7:0] fill, bit with_abort, int busy_pulse_at);
    int base = wr_cnt0;
    start0(mode, fill, with_abort);
    @(negedge clk);
    chk("busy0_running", 32'(bus0.busy), 1);
    if (busy_pulse_at > 0) begin
      wait_wr0(base + busy_pulse_at, N0);
      bus0.start = 1'b1;
      bus0.mode  = 2'd0;
      @(negedge clk);
      bus0.start = 1'b0;
    end
    wait_wr0(base + N0, N0 + 10);
    // Writer is in its done cycle now: this request must be dropped.
    bus0.start = 1'b1;
    bus0.mode  = 2'($urandom);
    @(negedge clk);
    bus0.start = 1'b0;
    chk("done0_seen", done0_q.size(), 0);
    chk("busy0_after", 32'(bus0.busy), 0);
    chk("wr_en0_after", 32'(bus0.wr_en), 0);
    chk("frame0_count", wr_cnt0 - base, N0);
  endtask

  task automatic abort_frame0(int mode, logic [7:0] fill, int after);
    int base = wr_cnt0;
    start0(mode, fill, 1'b0);
    wait_wr0(base + after, N0);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    chk("abort0_wr_en", 32'(bus0.wr_en), 0);
    chk("abort0_busy", 32'(bus0.busy), 0);
    chk("abort0_state", 32'(bus0.state), 32'(ST_IDLE));
    chk("abort0_remaining", exp0_q.size(), N0 - after);
    exp0_q.delete();
    done0_q.delete();
    repeat (4) @(negedge clk);
    chk("abort0_no_more", wr_cnt0 - base, after);
  endtask

  // ---------------- drivers: corner instance ----------------
  task automatic wait_wr1(int target, int budget);
    int n = 0;
    while (wr_cnt1 < target && n < budget) begin
      @(negedge clk);
      n++;
      bus1.mode      = 2'($urandom);
      bus1.fill_byte = 8'($urandom);
    end
    if (wr_cnt1 < target) fail_unexp("wait_wr1_timeout", wr_cnt1);
  endtask

  task automatic run_frame1(int mode, logic [7:0] fill, int abort_after);
    int base = wr_cnt1;
    @(negedge clk);
    bus1.start     = 1'b1;
    bus1.mode      = 2'(mode);
    bus1.fill_byte = fill;
    push_frame1(mode, fill, cyc + 1);
    @(negedge clk);
    bus1.start = 1'b0;
    if (abort_after > 0) begin
      wait_wr1(base + abort_after, N1 + 10);
      bus1.abort = 1'b1;
      @(negedge clk);
      bus1.abort = 1'b0;
      chk("abort1_remaining", exp1_q.size(), N1 - abort_after);
      exp1_q.delete();
      done1_q.delete();
      repeat (3) @(negedge clk);
    end else begin
      wait_wr1(base + N1, N1 + 10);
      @(negedge clk);
      chk("done1_seen", done1_q.size(), 0);
      chk("frame1_count", wr_cnt1 - base, N1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus0.start = 1'b0; bus0.mode = 2'd0; bus0.fill_byte = 8'h00; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.mode = 2'd0; bus1.fill_byte = 8'h00; bus1.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst0_busy", 32'(bus0.busy), 0);
    chk("rst0_done", 32'(bus0.done), 0);
    chk("rst0_wr_en", 32'(bus0.wr_en), 0);
    chk("rst0_wr_addr", 32'(bus0.wr_addr), 0);
    chk("rst0_wr_data", 32'(bus0.wr_data), 0);
    chk("rst0_state", 32'(bus0.state), 32'(ST_IDLE));
    chk("rst1_wr_en", 32'(bus1.wr_en), 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_wr_en", 32'(bus0.wr_en), 0);
    end

    // BORDER, with abort raised together with start (start must win).
    run_frame0(2, 8'($urandom), 1'b1, 0);
    // FILL 0x3C, then CHECKER.
    run_frame0(1, 8'h3C, 1'b0, 0);
    run_frame0(3, 8'($urandom), 1'b0, 0);
    // A CLEAR request at write 100 of a BORDER frame is ignored.
    run_frame0(2, 8'h00, 1'b0, 100);
    // Abort after 500 writes, then a fresh frame from address 0.
    abort_frame0(1, 8'hA5, 500);
    run_frame0(int'($urandom_range(0, 3)), 8'($urandom), 1'b0, 0);

    // Asynchronous reset in the middle of a frame.
    begin
      int base = wr_cnt0;
      start0(1, 8'h77, 1'b0);
      wait_wr0(base + 300, N0);
      rst = 1'b1;
      #1;
      chk("midrst_wr_en", 32'(bus0.wr_en), 0);
      chk("midrst_busy", 32'(bus0.busy), 0);
      chk("midrst_done", 32'(bus0.done), 0);
      chk("midrst_wr_addr", 32'(bus0.wr_addr), 0);
      chk("midrst_wr_data", 32'(bus0.wr_data), 0);
      chk("midrst_state", 32'(bus0.state), 32'(ST_IDLE));
      exp0_q.delete();
      first0_q.delete();
      done0_q.delete();
      last_addr0 = '0;
      last_data0 = '0;
      last_addr1 = '0;
      last_data1 = '0;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
        @(negedge clk);
        chk("postrst_wr_en", 32'(bus0.wr_en), 0);
      end
    end

    // Random frames on the large instance.
    repeat (2) run_frame0(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 0);

    // Corner instance: one byte per line, four lines.
    run_frame1(2, 8'h00, 0);
    repeat (24) begin
      if ($urandom_range(0, 3) == 0)
        run_frame1(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(1, N1 - 1)));
      else
        run_frame1(int'($urandom_range(0, 3)), 8'($urandom), 0);
    end

    repeat (5) @(negedge clk);
    chk("end_exp0_empty", exp0_q.size(), 0);
    chk("end_exp1_empty", exp1_q.size(), 0);
    chk("end_done0_empty", done0_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound: the whole sequence needs well under this.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/screen_pattern_writer.md
Name: screen_pattern_writer

Overview:
Parametrised successor to the fixed border painter. On a start request it writes one complete frame of a selectable pattern into the byte-wide monochrome screen RAM, one byte per clock. The screen is ROWS lines of COLS_BYTES bytes, LSB = leftmost pixel. It sits between the control logic and the screen RAM write port, and reports busy/done so the control logic can sequence redraws.

Parameters:
COLS_BYTES, 16, bytes per screen line (>=1)
ROWS, 128, lines per frame (>=2)
ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= COLS_BYTES*ROWS
DATA_W, 8, RAM data width; fixed at 8 (one byte = 8 pixels)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  request a frame write; sampled only in IDLE
mode  in  2  pattern select, latched with start: 0 CLEAR, 1 FILL, 2 BORDER, 3 CHECKER
fill_byte  in  8  fill value for FILL, latched with start
abort  in  1  synchronous cancel of a running frame
busy  out  1  high while in RUN
done  out  1  one-cycle pulse after the last byte of a completed frame
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  8  RAM write data

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0; row/col counters and latched mode/fill cleared.
- All outputs are registered.
- FSM states:
  - IDLE: on start=1, latch mode and fill_byte, clear row and col, go to RUN.
  - RUN: each cycle issue one write. On the final byte (row=ROWS-1, col=COLS_BYTES-1), go to DONE. If abort=1, go to IDLE with wr_en=0 that cycle and no done pulse.
  - DONE: done=1 for exactly one cycle, wr_en=0, then IDLE.
- Latency: start sampled at edge N → busy=1 and the first write (addr 0) visible after edge N+1. The last write is visible after edge N+ROWS*COLS_BYTES. done is high for the following cycle.
- Total writes per frame = ROWS*COLS_BYTES, with consecutive addresses and no gaps. Every byte is written, including zero interior bytes.
- Addressing: wr_addr = row*COLS_BYTES + col, computed incrementally (running base). No multiplier. Width truncated to ADDR_W.
- Counters: col wraps COLS_BYTES-1 → 0 and increments row. Row stops at ROWS-1.
- Pattern bytes, for (row, col):
  - CLEAR: 0x00.
  - FILL: fill_byte.
  - BORDER:
    - row 0 or row ROWS-1: 0xFF.
    - otherwise OR of: 0x01 if col=0; 0x80 if col=COLS_BYTES-1; else 0x00.
    - COLS_BYTES=1 therefore gives 0x81.
  - CHECKER: 0xAA when row is even, 0x55 when row is odd. Identical for every col.
- start while busy or in DONE: ignored, not queued.
- start and abort together in IDLE: start wins; abort is only meaningful in RUN.
- Inputs mode and fill_byte are don't-care after the latch; changes mid-frame have no effect.
- Reset mid-frame: immediate return to reset values. The partially written frame is left as-is.
- wr_en=0 in IDLE and DONE. wr_addr and wr_data hold their last values when wr_en=0.

Decomposition:
- Package screen_pkg:
  - mode encodings MODE_CLEAR/FILL/BORDER/CHECKER
  - byte constants BYTE_FULL=0xFF, EDGE_LEFT=0x01, EDGE_RIGHT=0x80, CHK_EVEN=0xAA, CHK_ODD=0x55
  - FSM state encoding
- One combinational sub-module, screen_pattern_gen: inputs (mode, fill_byte, row, col, first/last row flags, first/last col flags) → byte. Reusable by future sprite/text painters.
- Counters, FSM and output registers stay in the top.

Test Plan:
- Reset values: assert rst mid-stream → all outputs 0 immediately; release, then idle 10 cycles → wr_en never asserts.
- BORDER, defaults 16x128: start with mode=2 → exactly 2048 writes.
  - Addrs 0..15 and 2032..2047 = 0xFF; addr 16 = 0x01; addr 31 = 0x80; addr 17 = 0x00.
  - First write is 1 cycle after start; done pulses once, 1 cycle after the addr 2047 write.
- FILL and CHECKER: mode=1 with fill_byte=0x3C → all 2048 bytes = 0x3C. Then mode=3 → addr 0 = 0xAA, addr 16 = 0x55, addr 2047 = 0x55.
- Start while busy: pulse start again at write 100 with mode=0 → ignored; frame continues with the original mode; a single done pulse.
- Abort: assert abort after 500 writes → wr_en drops next cycle, busy=0, no done. A following start restarts at addr 0.
- Parameter corners: COLS_BYTES=1, ROWS=4, ADDR_W=2, BORDER → bytes FF,81,81,FF at addrs 0..3, then done.
